// File: rtl/mem_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Holds the response-owner encoding, default widths and the all-ones byte enable.
package mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Wide enough for any practical DATA_W/8; users slice the low bits they need.
  localparam logic [127:0] BE_ALL = {128{1'b1}};

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DM   = 2'd2
  } resp_owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Two-input fixed-priority selector with an override that lets the
// low-priority requester win for one cycle (used by the starvation guard).
module mem_arb_prio (
  input  logic hi_req,
  input  logic lo_req,
  input  logic force_lo,
  output logic hi_gnt,
  output logic lo_gnt
);

  // Pick one winner; the override only matters when the low side is asking.
  always_comb begin
    hi_gnt = 1'b0;
    lo_gnt = 1'b0;
    if (force_lo && lo_req) begin
      lo_gnt = 1'b1;
    end else if (hi_req) begin
      hi_gnt = 1'b1;
    end else if (lo_req) begin
      lo_gnt = 1'b1;
    end else begin
      hi_gnt = 1'b0;
      lo_gnt = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous-read memory between fetch and load/store.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                RST_X,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  resp_owner_t       resp_q;
  resp_owner_t       resp_d;
  logic [DATA_W-1:0] if_hold_q;
  logic [DATA_W-1:0] dm_hold_q;
  logic              force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;

  assign force_if = (starve_q == SW'(STARVE_MAX));

  // Count consecutive cycles fetch asks but loses; saturate at the limit.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      starve_q <= '0;
    end else if (!if_req || if_gnt) begin
      starve_q <= '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_q <= starve_q + SW'(1);
    end else begin
      starve_q <= starve_q;
    end
  end
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign force_if = 1'b0;
`endif

  // Requests are masked during reset so no grant or memory access leaks out.
  mem_arb_prio u_prio (
    .hi_req   (dm_req & RST_X),
    .lo_req   (if_req & RST_X),
    .force_lo (force_if),
    .hi_gnt   (dm_gnt),
    .lo_gnt   (if_gnt)
  );

  // Drive the memory port from whichever side won; all zeros when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_be    = dm_we ? dm_be : BE_ALL[BE_W-1:0];
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_we    = 1'b0;
      mem_be    = BE_ALL[BE_W-1:0];
      mem_addr  = if_addr;
      mem_wdata = '0;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Stores produce no read data, so they leave the tracker empty.
  always_comb begin
    resp_d = RESP_NONE;
    if (dm_gnt && !dm_we) begin
      resp_d = RESP_DM;
    end else if (if_gnt) begin
      resp_d = RESP_IF;
    end else begin
      resp_d = RESP_NONE;
    end
  end

  // Response owner register; reset drops any in-flight read.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      resp_q <= RESP_NONE;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Each port keeps its last read data while the other port owns the bus.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      if_hold_q <= '0;
      dm_hold_q <= '0;
    end else begin
      if (resp_q == RESP_IF) begin
        if_hold_q <= mem_rdata;
      end else begin
        if_hold_q <= if_hold_q;
      end
      if (resp_q == RESP_DM) begin
        dm_hold_q <= mem_rdata;
      end else begin
        dm_hold_q <= dm_hold_q;
      end
    end
  end

  assign if_rvalid = (resp_q == RESP_IF);
  assign dm_rvalid = (resp_q == RESP_DM);
  assign if_rdata  = (resp_q == RESP_IF) ? mem_rdata : if_hold_q;
  assign dm_rdata  = (resp_q == RESP_DM) ? mem_rdata : dm_hold_q;

endmodule
